// File: rtl/line_fetch.sv
// Fetches one cache line (or one uncached word) over pipelined Wishbone; each returned word appears one cycle after its ack.
// Latency: strobes start the cycle after i_req; o_done coincides with the final o_valid. Slave stall holds o_wb_addr; o_busy blocks new requests.
module line_fetch #(
   parameter int ADDRESS_WIDTH = 30,
   parameter int DATA_WIDTH    = 32,
   parameter int LGLINE        = 3
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_req,
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   input  logic                     i_cachable,
   output logic                     o_busy,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_err,
   input  logic [DATA_WIDTH-1:0]    i_wb_data,
   output logic                     o_valid,
   output logic [LGLINE-1:0]        o_idx,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_done,
   output logic                     o_err
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam logic [LGLINE:0] LINE_CNT = (LGLINE+1)'(1 << LGLINE);
   localparam logic [LGLINE:0] ONE_CNT  = (LGLINE+1)'(1);

   typedef enum logic {IDLE, BUS} state_t;

   state_t          r_state;
   logic            r_wb_cyc;
   logic            r_wb_stb;
   logic [AW-1:0]   r_wb_addr;
   logic [LGLINE:0] r_req_left;
   logic [LGLINE:0] r_ack_cnt;
   logic [LGLINE:0] r_ack_need;
   logic            r_valid;
   logic            r_done;
   logic            r_err;
   logic [LGLINE-1:0] r_idx;
   logic [DW-1:0]   r_data;

   logic [AW-1:0]   w_base;
   logic [LGLINE:0] w_count;
   logic            w_strobe_ok;
   logic            w_ack;
   logic            w_last_ack;

   assign w_base      = i_cachable ? {i_addr[AW-1:LGLINE], {LGLINE{1'b0}}} : i_addr;
   assign w_count     = i_cachable ? LINE_CNT : ONE_CNT;
   assign w_strobe_ok = r_wb_stb && !i_wb_stall;
   // Acks outside a cycle or past the expected count never reach the output path.
   assign w_ack       = r_wb_cyc && i_wb_ack && !i_wb_err && (r_ack_cnt < r_ack_need);
   assign w_last_ack  = w_ack && (r_ack_cnt == r_ack_need - ONE_CNT);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_wb_cyc   <= 1'b0;
         r_wb_stb   <= 1'b0;
         r_wb_addr  <= '0;
         r_req_left <= '0;
         r_ack_cnt  <= '0;
         r_ack_need <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_idx      <= '0;
         r_data     <= '0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         if (r_state == IDLE) begin
            if (i_req) begin
               r_state    <= BUS;
               r_wb_cyc   <= 1'b1;
               r_wb_stb   <= 1'b1;
               r_wb_addr  <= w_base;
               r_req_left <= w_count;
               r_ack_need <= w_count;
               r_ack_cnt  <= '0;
            end
         end else begin
            if (w_strobe_ok) begin
               r_wb_addr  <= r_wb_addr + AW'(1);
               r_req_left <= r_req_left - ONE_CNT;
               if (r_req_left == ONE_CNT)
                  r_wb_stb <= 1'b0;
            end
            // Error wins over a simultaneous ack and aborts the remaining strobes.
            if (r_wb_cyc && i_wb_err) begin
               r_wb_cyc <= 1'b0;
               r_wb_stb <= 1'b0;
               r_state  <= IDLE;
               r_err    <= 1'b1;
               r_done   <= 1'b1;
            end else if (w_ack) begin
               r_valid   <= 1'b1;
               r_data    <= i_wb_data;
               r_idx     <= r_ack_cnt[LGLINE-1:0];
               r_ack_cnt <= r_ack_cnt + ONE_CNT;
               if (w_last_ack) begin
                  r_wb_cyc <= 1'b0;
                  r_wb_stb <= 1'b0;
                  r_state  <= IDLE;
                  r_done   <= 1'b1;
               end
            end
         end
      end
   end

   assign o_busy    = (r_state == BUS);
   assign o_wb_cyc  = r_wb_cyc;
   assign o_wb_stb  = r_wb_stb;
   assign o_wb_addr = r_wb_addr;
   assign o_valid   = r_valid;
   assign o_idx     = r_idx;
   assign o_data    = r_data;
   assign o_done    = r_done;
   assign o_err     = r_err;

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: a one-cycle-latency Wishbone slave returns data = {2'b10, address}.
module tb_line_fetch;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int LG = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          cach = 1'b0;
   logic          stall = 1'b0;
   logic          ack = 1'b0;
   logic          err = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          o_busy, o_wb_cyc, o_wb_stb, o_valid, o_done, o_err;
   logic [AW-1:0] o_wb_addr;
   logic [LG-1:0] o_idx;
   logic [DW-1:0] o_data;

   int n_vec = 0;
   int n_err = 0;

   logic [AW-1:0] q_stb_addr[$];
   logic [AW-1:0] q_stall_addr[$];
   int            q_vidx[$];
   logic [DW-1:0] q_vdata[$];
   bit            done_seen, done_valid, done_err, done_cyc, first_busy;
   int            done_idx, first_stb_it;

   line_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LGLINE(LG)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_addr(addr), .i_cachable(cach),
      .o_busy(o_busy), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
      .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err), .i_wb_data(wdata),
      .o_valid(o_valid), .o_idx(o_idx), .o_data(o_data), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   // Called just after a falling edge; runs one transfer and records what the DUT did.
   task automatic bus_run(input logic [AW-1:0] a, input logic c, input int stall_strobe,
                          input int stall_len, input int err_ack, input int rst_after,
                          input logic hold_req);
      int pending, accepted, acks, stall_left;
      logic stalled;
      logic [DW-1:0] pend_data;
      pending = 0; accepted = 0; acks = 0; stall_left = stall_len; pend_data = '0;
      q_stb_addr.delete(); q_stall_addr.delete(); q_vidx.delete(); q_vdata.delete();
      done_seen = 0; done_valid = 0; done_err = 0; done_cyc = 1; done_idx = -1;
      first_stb_it = -1; first_busy = 0;
      req = 1'b1; addr = a; cach = c;
      for (int it = 1; it <= 60; it++) begin
         @(negedge clk);
         if (hold_req) begin addr = 30'h3FFF_FFF0; cach = 1'b0; end
         else req = 1'b0;
         if (it == 1) first_busy = o_busy;
         if (o_wb_stb && first_stb_it < 0) first_stb_it = it;
         if (o_valid) begin q_vidx.push_back(int'(o_idx)); q_vdata.push_back(o_data); end
         if (o_done) begin
            done_seen = 1; done_valid = o_valid; done_err = o_err;
            done_idx = int'(o_idx); done_cyc = o_wb_cyc;
            req = 1'b0; ack = 1'b0; err = 1'b0; stall = 1'b0;
            return;
         end
         if (rst_after > 0 && q_vidx.size() == rst_after) begin
            rst_n = 1'b0; req = 1'b0; ack = 1'b0; err = 1'b0; stall = 1'b0;
            return;
         end
         ack = 1'b0; err = 1'b0;
         if (pending != 0) begin
            if (acks == err_ack) err = 1'b1;
            else ack = 1'b1;
            wdata = pend_data;
            acks++;
         end
         pending = 0;
         stalled = o_wb_stb && (accepted == stall_strobe) && (stall_left > 0);
         if (stalled) begin stall_left--; q_stall_addr.push_back(o_wb_addr); end
         stall = stalled;
         if (o_wb_stb) q_stb_addr.push_back(o_wb_addr);
         if (o_wb_stb && !stalled) begin
            accepted++; pending = 1; pend_data = {2'b10, o_wb_addr};
         end
      end
      n_vec++; n_err++;
      $display("FAIL timeout: no o_done within 60 cycles (got none, want one)");
      req = 1'b0; ack = 1'b0; err = 1'b0; stall = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++; if ({o_busy, o_wb_cyc, o_wb_stb, o_valid, o_done, o_err} !== 6'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 000000", {o_busy, o_wb_cyc, o_wb_stb, o_valid, o_done, o_err}); end
      n_vec++; if ({o_wb_addr, o_idx, o_data} !== '0) begin
         n_err++; $display("FAIL reset_data: got %0h/%0h/%0h want 0", o_wb_addr, o_idx, o_data); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if ({o_busy, o_wb_cyc, o_wb_stb} !== 3'b0) begin
         n_err++; $display("FAIL idle_after_reset: got %b want 000", {o_busy, o_wb_cyc, o_wb_stb}); end
   endtask

   task automatic test_cache_line();
      logic [AW-1:0] base;
      base = 30'h1000_0000;
      bus_run(30'h1000_0005, 1'b1, -1, 0, -1, 0, 1'b0);
      n_vec++; if (first_stb_it !== 1 || first_busy !== 1'b1) begin
         n_err++; $display("FAIL line_start: got stb_it %0d busy %0b want 1 1", first_stb_it, first_busy); end
      n_vec++; if (q_stb_addr.size() !== 8) begin
         n_err++; $display("FAIL line_nstb: got %0d want 8", q_stb_addr.size()); end
      foreach (q_stb_addr[i]) begin
         n_vec++; if (q_stb_addr[i] !== base + AW'(i)) begin
            n_err++; $display("FAIL line_addr%0d: got %0h want %0h", i, q_stb_addr[i], base + AW'(i)); end
      end
      n_vec++; if (q_vidx.size() !== 8) begin
         n_err++; $display("FAIL line_nvalid: got %0d want 8", q_vidx.size()); end
      foreach (q_vidx[i]) begin
         n_vec++; if (q_vidx[i] !== i || q_vdata[i] !== {2'b10, base + AW'(i)}) begin
            n_err++; $display("FAIL line_word%0d: got idx %0d data %0h want idx %0d data %0h",
                              i, q_vidx[i], q_vdata[i], i, {2'b10, base + AW'(i)}); end
      end
      n_vec++; if (!done_seen || !done_valid || done_err || done_idx !== 7 || done_cyc) begin
         n_err++; $display("FAIL line_done: got seen %0b valid %0b err %0b idx %0d cyc %0b want 1 1 0 7 0",
                           done_seen, done_valid, done_err, done_idx, done_cyc); end
   endtask

   task automatic test_uncached();
      bus_run(30'h0000_1234, 1'b0, -1, 0, -1, 0, 1'b0);
      n_vec++; if (q_stb_addr.size() !== 1 || q_stb_addr[0] !== 30'h0000_1234) begin
         n_err++; $display("FAIL unc_strobe: got n %0d addr %0h want 1 1234", q_stb_addr.size(), q_stb_addr[0]); end
      n_vec++; if (q_vidx.size() !== 1 || q_vidx[0] !== 0 || q_vdata[0] !== {2'b10, 30'h0000_1234}) begin
         n_err++; $display("FAIL unc_word: got n %0d idx %0d data %0h want 1 0 80001234",
                           q_vidx.size(), q_vidx[0], q_vdata[0]); end
      n_vec++; if (!done_seen || !done_valid || done_cyc || done_err) begin
         n_err++; $display("FAIL unc_done: got seen %0b valid %0b cyc %0b err %0b want 1 1 0 0",
                           done_seen, done_valid, done_cyc, done_err); end
      @(negedge clk);
      n_vec++; if ({o_done, o_valid, o_wb_cyc, o_busy} !== 4'b0) begin
         n_err++; $display("FAIL unc_pulse: got %b want 0000", {o_done, o_valid, o_wb_cyc, o_busy}); end
   endtask

   task automatic test_stall();
      logic [AW-1:0] base, exp_a;
      base = 30'h0ABC_DE10;
      // Request held high with a junk address for the whole transfer must be ignored.
      bus_run(30'h0ABC_DE13, 1'b1, 2, 3, -1, 0, 1'b1);
      n_vec++; if (q_stall_addr.size() !== 3) begin
         n_err++; $display("FAIL stall_cycles: got %0d want 3", q_stall_addr.size()); end
      foreach (q_stall_addr[i]) begin
         n_vec++; if (q_stall_addr[i] !== base + AW'(2)) begin
            n_err++; $display("FAIL stall_hold%0d: got %0h want %0h", i, q_stall_addr[i], base + AW'(2)); end
      end
      n_vec++; if (q_stb_addr.size() !== 11) begin
         n_err++; $display("FAIL stall_nstb: got %0d want 11", q_stb_addr.size()); end
      foreach (q_stb_addr[i]) begin
         exp_a = base + AW'((i < 2) ? i : (i < 6) ? 2 : i - 3);
         n_vec++; if (q_stb_addr[i] !== exp_a) begin
            n_err++; $display("FAIL stall_addr%0d: got %0h want %0h", i, q_stb_addr[i], exp_a); end
      end
      n_vec++; if (q_vidx.size() !== 8 || !done_seen || done_idx !== 7) begin
         n_err++; $display("FAIL stall_count: got n %0d done %0b idx %0d want 8 1 7", q_vidx.size(), done_seen, done_idx); end
      foreach (q_vidx[i]) begin
         n_vec++; if (q_vidx[i] !== i || q_vdata[i] !== {2'b10, base + AW'(i)}) begin
            n_err++; $display("FAIL stall_word%0d: got idx %0d data %0h want idx %0d", i, q_vidx[i], q_vdata[i], i); end
      end
   endtask

   task automatic test_error();
      bus_run(30'h0000_0100, 1'b1, -1, 0, 3, 0, 1'b0);
      n_vec++; if (q_vidx.size() !== 3) begin
         n_err++; $display("FAIL err_nvalid: got %0d want 3", q_vidx.size()); end
      n_vec++; if (!done_seen || !done_err || done_valid || done_cyc) begin
         n_err++; $display("FAIL err_done: got seen %0b err %0b valid %0b cyc %0b want 1 1 0 0",
                           done_seen, done_err, done_valid, done_cyc); end
      for (int k = 0; k < 3; k++) begin
         ack = 1'b1; wdata = 32'hDEAD_0000 + DW'(k);
         @(negedge clk);
         n_vec++; if ({o_valid, o_wb_cyc, o_err, o_done} !== 4'b0) begin
            n_err++; $display("FAIL err_stray%0d: got %b want 0000", k, {o_valid, o_wb_cyc, o_err, o_done}); end
      end
      ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus_run(30'h2222_2228, 1'b1, -1, 0, -1, 2, 1'b0);
      #1;
      n_vec++; if ({o_busy, o_wb_cyc, o_wb_stb, o_valid, o_done, o_err} !== 6'b0) begin
         n_err++; $display("FAIL rst_mid_ctrl: got %b want 000000", {o_busy, o_wb_cyc, o_wb_stb, o_valid, o_done, o_err}); end
      n_vec++; if ({o_wb_addr, o_idx, o_data} !== '0) begin
         n_err++; $display("FAIL rst_mid_data: got %0h/%0h/%0h want 0", o_wb_addr, o_idx, o_data); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ack = 1'b1; wdata = 32'hBAD0_0000 + DW'(k);
         @(negedge clk);
         n_vec++; if ({o_valid, o_wb_cyc, o_wb_stb, o_busy} !== 4'b0) begin
            n_err++; $display("FAIL rst_stray%0d: got %b want 0000", k, {o_valid, o_wb_cyc, o_wb_stb, o_busy}); end
      end
      ack = 1'b0;
      bus_run(30'h0123_4567, 1'b1, -1, 0, -1, 0, 1'b0);
      n_vec++; if (q_vidx.size() !== 8 || !done_seen || done_idx !== 7 || q_stb_addr[0] !== 30'h0123_4560) begin
         n_err++; $display("FAIL rst_relaunch: got n %0d done %0b idx %0d base %0h want 8 1 7 1234560",
                           q_vidx.size(), done_seen, done_idx, q_stb_addr[0]); end
      n_vec++; if (q_vdata[7] !== {2'b10, 30'h0123_4567}) begin
         n_err++; $display("FAIL rst_relaunch_data: got %0h want %0h", q_vdata[7], {2'b10, 30'h0123_4567}); end
   endtask

   task automatic test_back_to_back();
      bus_run(30'h3FFF_FFFF, 1'b0, -1, 0, -1, 0, 1'b0);
      n_vec++; if (!done_seen || q_vdata[0] !== {2'b10, 30'h3FFF_FFFF}) begin
         n_err++; $display("FAIL b2b_first: got done %0b data %0h want 1 bfffffff", done_seen, q_vdata[0]); end
      // Second request issued in the very cycle o_done is high.
      bus_run(30'h0000_0009, 1'b1, -1, 0, -1, 0, 1'b0);
      n_vec++; if (first_stb_it !== 1 || first_busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_accept: got stb_it %0d busy %0b want 1 1", first_stb_it, first_busy); end
      n_vec++; if (q_stb_addr.size() !== 8 || q_stb_addr[0] !== 30'h0000_0008 || q_vidx.size() !== 8 || done_idx !== 7) begin
         n_err++; $display("FAIL b2b_line: got nstb %0d base %0h nvalid %0d idx %0d want 8 8 8 7",
                           q_stb_addr.size(), q_stb_addr[0], q_vidx.size(), done_idx); end
   endtask

   initial begin
      test_reset();
      test_cache_line();
      test_uncached();
      test_stall();
      test_error();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
